// File: rtl/crc16_pkg.sv
// ----------------------------------------------------------------------------
// crc16_pkg
// Shared constants for the CRC16-MODBUS frame checker and its byte-update
// helper.
//   CRC16_POLY / CRC16_INIT : reflected MODBUS polynomial and seed
//   ERR_*                   : err_code values reported at end of frame
//   state_t                 : frame checker FSM encoding
// ----------------------------------------------------------------------------
package crc16_pkg;

  localparam logic [15:0] CRC16_POLY = 16'hA001;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CRC     = 2'd1;
  localparam logic [1:0] ERR_LEN     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PAYLOAD = 3'd1,
    CRC_LO  = 3'd2,
    CRC_HI  = 3'd3,
    DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/crc16_byte_update.sv
// ----------------------------------------------------------------------------
// crc16_byte_update
// Purely combinational CRC16-MODBUS update of one byte, LSB first, using the
// reflected polynomial. Eight shift/XOR steps, unrolled by the loop.
//   crc_in  [15:0] : running CRC before this byte
//   data    [7:0]  : byte to fold in
//   crc_out [15:0] : running CRC after this byte
// ----------------------------------------------------------------------------
module crc16_byte_update
  import crc16_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  always_comb begin
    c = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC16_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/crc16_frame_checker.sv
// ----------------------------------------------------------------------------
// crc16_frame_checker
// Receive-side CRC16-MODBUS frame checker. Frames arrive as
// LEN, payload[LEN], CRC_LO, CRC_HI. Payload bytes are forwarded one cycle
// after their handshake; the CRC over the payload (LEN excluded) is compared
// against the received CRC and the result is reported with a frame_done pulse.
//
// Optional feature: define RX_TIMEOUT_EN to build an inter-byte watchdog that
// aborts a frame after TIMEOUT_CYCLES idle clocks (err_code = 3).
//
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   s_data/s_valid      : incoming byte stream
//   s_ready             : low only during the one-cycle DONE state
//   m_data/m_valid      : forwarded payload byte, one-cycle strobe
//   m_last              : marks the final payload byte
//   frame_done          : one-cycle pulse at end of every frame
//   frame_ok, err_code  : result of last frame, held until next LEN
//   crc_calc, crc_rx    : computed and received CRC, held after each frame
// ----------------------------------------------------------------------------
module crc16_frame_checker
  import crc16_pkg::*;
#(
  parameter int MAX_LEN        = 64,
  parameter int TIMEOUT_CYCLES = 1024
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [1:0]  err_code,
  output logic [15:0] crc_calc,
  output logic [15:0] crc_rx
);

  state_t      state_q, state_d;
  logic [7:0]  rem_cnt;
  logic [15:0] crc_next;
  logic        acc;
  logic        len_bad;
  logic        tmo_expire;

  assign s_ready = (state_q != DONE);
  assign acc     = s_valid && s_ready;
  assign len_bad = (s_data == 8'd0) || ({24'd0, s_data} > 32'(MAX_LEN));

  crc16_byte_update u_crc (
    .crc_in  (crc_calc),
    .data    (s_data),
    .crc_out (crc_next)
  );

`ifdef RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;
  logic          busy;

  assign busy = (state_q == PAYLOAD) || (state_q == CRC_LO) || (state_q == CRC_HI);
  // An accepted byte always beats expiry in the same cycle.
  assign tmo_expire = busy && !acc && (tmo_cnt == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (acc || !busy) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TW'(TIMEOUT_CYCLES)) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end
`else
  // Watchdog compiled out: the abort term is tied off for any legal
  // TIMEOUT_CYCLES, so the FSM waits indefinitely between bytes.
  assign tmo_expire = (TIMEOUT_CYCLES < 0);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tmo_expire) begin
      state_d = DONE;
    end else begin
      case (state_q)
        IDLE:    if (acc) state_d = len_bad ? DONE : PAYLOAD;
        PAYLOAD: if (acc && (rem_cnt == 8'd1)) state_d = CRC_LO;
        CRC_LO:  if (acc) state_d = CRC_HI;
        CRC_HI:  if (acc) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output / datapath registers: everything below is visible one cycle
  // after the handshake that caused it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_cnt    <= 8'd0;
      m_data     <= 8'h00;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      err_code   <= ERR_NONE;
      crc_calc   <= CRC16_INIT;
      crc_rx     <= 16'h0000;
    end else begin
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      frame_done <= 1'b0;
      if (tmo_expire) begin
        frame_done <= 1'b1;
        frame_ok   <= 1'b0;
        err_code   <= ERR_TIMEOUT;
      end else begin
        case (state_q)
          IDLE: begin
            if (acc) begin
              if (len_bad) begin
                frame_done <= 1'b1;
                frame_ok   <= 1'b0;
                err_code   <= ERR_LEN;
              end else begin
                rem_cnt  <= s_data;
                crc_calc <= CRC16_INIT;
                frame_ok <= 1'b0;
                err_code <= ERR_NONE;
              end
            end
          end
          PAYLOAD: begin
            if (acc) begin
              crc_calc <= crc_next;
              m_data   <= s_data;
              m_valid  <= 1'b1;
              m_last   <= (rem_cnt == 8'd1);
              rem_cnt  <= rem_cnt - 8'd1;
            end
          end
          CRC_LO: begin
            if (acc) crc_rx[7:0] <= s_data;
          end
          CRC_HI: begin
            if (acc) begin
              crc_rx[15:8] <= s_data;
              frame_done   <= 1'b1;
              if (crc_calc == {s_data, crc_rx[7:0]}) begin
                frame_ok <= 1'b1;
                err_code <= ERR_NONE;
              end else begin
                frame_ok <= 1'b0;
                err_code <= ERR_CRC;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_crc16_frame_checker.sv
// ----------------------------------------------------------------------------
// tb_crc16_frame_checker
// Directed bench for crc16_frame_checker. Inputs change on the falling edge;
// outputs are sampled on the falling edge after the handshake edge.
// ----------------------------------------------------------------------------
module tb_crc16_frame_checker;

  localparam int MAX_LEN = 64;
  localparam int TMO     = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_last;
  logic        frame_done;
  logic        frame_ok;
  logic [1:0]  err_code;
  logic [15:0] crc_calc;
  logic [15:0] crc_rx;

  int errors = 0;
  int checks = 0;
  int stalls = 0;
  int cyc    = 0;
  int c0;
  logic       seen;
  logic [1:0] seen_err;
  logic [7:0] frm[$];

  crc16_frame_checker #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_last     (m_last),
    .frame_done (frame_done),
    .frame_ok   (frame_ok),
    .err_code   (err_code),
    .crc_calc   (crc_calc),
    .crc_rx     (crc_rx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input string what,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s: observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  // Present one byte and return on the falling edge after it was accepted.
  task automatic send(input logic [7:0] b);
    int guard;
    guard = 0;
    s_data  = b;
    s_valid = 1'b1;
    while (!s_ready && guard < 8) begin
      @(negedge clk);
      guard++;
      stalls++;
    end
    chk("send", "s_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Send the frame held in frm and check forwarding and the final result.
  task automatic run_frame(input string tag, input logic exp_ok, input logic [1:0] exp_err,
                           input logic [15:0] exp_calc, input logic [15:0] exp_rx);
    int len;
    len = int'(frm[0]);
    for (int i = 0; i < frm.size(); i++) begin
      send(frm[i]);
      if (i == 0) begin
        chk(tag, "len_err_clr", 32'(err_code), 32'd0);
        chk(tag, "len_ok_clr", 32'(frame_ok), 32'd0);
        chk(tag, "len_no_mvalid", 32'(m_valid), 32'd0);
      end else if (i <= len) begin
        chk(tag, "m_valid", 32'(m_valid), 32'd1);
        chk(tag, "m_data", 32'(m_data), 32'(frm[i]));
        chk(tag, "m_last", 32'(m_last), 32'(i == len));
      end else if (i == len + 1) begin
        chk(tag, "crclo_no_mvalid", 32'(m_valid), 32'd0);
        chk(tag, "crclo_no_done", 32'(frame_done), 32'd0);
      end
    end
    chk(tag, "frame_done", 32'(frame_done), 32'd1);
    chk(tag, "s_ready_done", 32'(s_ready), 32'd0);
    chk(tag, "frame_ok", 32'(frame_ok), 32'(exp_ok));
    chk(tag, "err_code", 32'(err_code), 32'(exp_err));
    chk(tag, "crc_calc", 32'(crc_calc), 32'(exp_calc));
    chk(tag, "crc_rx", 32'(crc_rx), 32'(exp_rx));
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    chk("reset", "s_ready", 32'(s_ready), 32'd1);
    chk("reset", "m_data", 32'(m_data), 32'h00);
    chk("reset", "m_valid", 32'(m_valid), 32'd0);
    chk("reset", "frame_done", 32'(frame_done), 32'd0);
    chk("reset", "frame_ok", 32'(frame_ok), 32'd0);
    chk("reset", "err_code", 32'(err_code), 32'd0);
    chk("reset", "crc_calc", 32'(crc_calc), 32'hFFFF);
    chk("reset", "crc_rx", 32'(crc_rx), 32'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    // MODBUS read-holding-register request
    frm = '{8'h06, 8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
    run_frame("modbus", 1'b1, 2'd0, 16'h0A84, 16'h0A84);

    // Check string "123456789"
    frm = '{8'h09, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
            8'h37, 8'h4B};
    run_frame("check9", 1'b1, 2'd0, 16'h4B37, 16'h4B37);

    // Illegal lengths, presented during DONE of the previous frame
    send(8'h00);
    chk("len0", "frame_done", 32'(frame_done), 32'd1);
    chk("len0", "err_code", 32'(err_code), 32'd2);
    chk("len0", "frame_ok", 32'(frame_ok), 32'd0);
    chk("len0", "m_valid", 32'(m_valid), 32'd0);
    send(8'(MAX_LEN + 1));
    chk("len65", "frame_done", 32'(frame_done), 32'd1);
    chk("len65", "err_code", 32'(err_code), 32'd2);
    chk("len65", "m_valid", 32'(m_valid), 32'd0);
    frm = '{8'h06, 8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
    run_frame("after_len", 1'b1, 2'd0, 16'h0A84, 16'h0A84);

    // Corrupted CRC high byte
    frm = '{8'h09, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
            8'h37, 8'h4C};
    run_frame("badcrc", 1'b0, 2'd1, 16'h4B37, 16'h4C37);

    // Back-to-back frames: 9 + 12 bytes, one DONE cycle each
    @(negedge clk);
    stalls = 0;
    c0 = cyc;
    frm = '{8'h06, 8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
    run_frame("b2b_a", 1'b1, 2'd0, 16'h0A84, 16'h0A84);
    frm = '{8'h09, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
            8'h37, 8'h4B};
    run_frame("b2b_b", 1'b1, 2'd0, 16'h4B37, 16'h4B37);
    chk("b2b", "cycles", 32'(cyc - c0 + 1), 32'd23);
    chk("b2b", "stalls", 32'(stalls), 32'd1);

    // Long stall after the third payload byte
    send(8'h06);
    send(8'h01);
    send(8'h03);
    send(8'h00);
    seen = 1'b0;
    seen_err = 2'd0;
    for (int k = 0; k < TMO + 8; k++) begin
      @(negedge clk);
      if (frame_done && !seen) begin
        seen = 1'b1;
        seen_err = err_code;
      end
    end
`ifdef RX_TIMEOUT_EN
    chk("stall", "timeout_done", 32'(seen), 32'd1);
    chk("stall", "timeout_err", 32'(seen_err), 32'd3);
    chk("stall", "timeout_ok", 32'(frame_ok), 32'd0);
`else
    chk("stall", "no_done", 32'(seen), 32'd0);
    send(8'h00);
    send(8'h00);
    send(8'h01);
    chk("stall", "m_last", 32'(m_last), 32'd1);
    send(8'h84);
    send(8'h0A);
    chk("stall", "frame_done", 32'(frame_done), 32'd1);
    chk("stall", "frame_ok", 32'(frame_ok), 32'd1);
    chk("stall", "crc_calc", 32'(crc_calc), 32'h0A84);
`endif

    // Asynchronous reset mid-payload
    send(8'h06);
    send(8'h01);
    send(8'h03);
    rst_n = 1'b0;
    #1;
    chk("midrst", "m_data", 32'(m_data), 32'h00);
    chk("midrst", "m_valid", 32'(m_valid), 32'd0);
    chk("midrst", "crc_calc", 32'(crc_calc), 32'hFFFF);
    chk("midrst", "crc_rx", 32'(crc_rx), 32'h0000);
    chk("midrst", "err_code", 32'(err_code), 32'd0);
    chk("midrst", "frame_done", 32'(frame_done), 32'd0);
    chk("midrst", "s_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    frm = '{8'h09, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
            8'h37, 8'h4B};
    run_frame("post_rst", 1'b1, 2'd0, 16'h4B37, 16'h4B37);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/crc16_frame_checker.md
# crc16_frame_checker

Receive-side companion to the LoraLite CRC16-MODBUS generator. It consumes a byte stream framed as LEN, payload, CRC_LO, CRC_HI and forwards the payload bytes as they arrive. It computes CRC16-MODBUS over the payload at one byte per cycle and reports pass or fail, with an error code, at the end of every frame. It sits between the UART/radio byte receiver and the TinyQV peripheral register file.

## Interface
Parameters:
- MAX_LEN, 64: largest legal payload length in bytes (1..255).
- TIMEOUT_CYCLES, 1024: inter-byte gap, in clocks, that aborts a frame (used only with RX_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- s_data  in  8  incoming byte.
- s_valid  in  1  s_data valid.
- s_ready  out  1  byte accepted when s_valid && s_ready.
- m_data  out  8  payload byte forwarded.
- m_valid  out  1  one-cycle strobe per payload byte; no backpressure.
- m_last  out  1  with m_valid, marks the final payload byte.
- frame_done  out  1  one-cycle pulse when a frame ends, whether it passed or failed.
- frame_ok  out  1  result of the last frame; held until the next LEN byte is accepted.
- err_code  out  2  0 none, 1 CRC mismatch, 2 illegal LEN, 3 timeout; held like frame_ok.
- crc_calc  out  16  CRC computed over the payload; held after each frame.
- crc_rx  out  16  received CRC {CRC_HI, CRC_LO}; held after each frame.

## Operation
- FSM states: IDLE, PAYLOAD, CRC_LO, CRC_HI, DONE.
- IDLE:
  - An accepted byte is LEN.
  - LEN==0 or LEN>MAX_LEN: go to DONE with err_code=2.
  - Otherwise: load the remaining-byte counter with LEN, set the CRC register to 0xFFFF, clear frame_ok and err_code to 0, go to PAYLOAD.
- PAYLOAD:
  - Each accepted byte updates crc = byte_update(crc, byte), using reflected polynomial 0xA001, LSB first.
  - The byte is forwarded on m_data/m_valid in the same cycle it is registered.
  - The counter decrements on each byte; the byte taken with counter==1 asserts m_last and moves the FSM to CRC_LO.
- CRC_LO: capture crc_rx[7:0], go to CRC_HI.
- CRC_HI: capture crc_rx[15:8], go to DONE. Result: frame_ok = (crc_calc == {byte, crc_rx[7:0]}); otherwise err_code=1.
- DONE: lasts exactly one cycle. frame_done=1, s_ready=0, then return to IDLE.
- s_ready = 1 in every state except DONE.
- The CRC is not computed over LEN. crc_calc is the payload CRC only.

## Timing
- Reset values:
  - s_ready=1 (combinational from state, with state = IDLE).
  - m_data=0x00; m_valid, m_last, frame_done, frame_ok = 0.
  - err_code=0, crc_calc=0xFFFF, crc_rx=0x0000.
- Throughput is one byte per clock, with zero bubbles inside a frame.
- m_valid/m_data appear one cycle after the payload byte's handshake (registered).
- frame_done rises one cycle after CRC_HI is accepted, or one cycle after an illegal LEN. frame_ok and err_code are valid in that same cycle.
- Back-to-back frames: the LEN of the next frame may be presented during DONE. It is not accepted (s_ready=0) and is taken on the following cycle.
- Gaps (s_valid=0) are legal in any state; the FSM holds.
- rst_n asserted mid-frame aborts immediately. All outputs take their reset values and no frame_done is produced.
- The remaining-byte counter is 8 bits wide; it never wraps because LEN≥1 is enforced.

## Configuration
- RX_TIMEOUT_EN defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on each accepted byte and increments in PAYLOAD/CRC_LO/CRC_HI while no byte is accepted.
  - Reaching TIMEOUT_CYCLES aborts to DONE with err_code=3.
  - m_last is not generated for an aborted frame.
  - If a byte handshake and expiry happen in the same cycle, the byte wins and the counter clears.
- RX_TIMEOUT_EN undefined: no counter logic is built; the FSM waits indefinitely, and err_code=3 never occurs.

## Structure
- Package crc16_pkg holds:
  - CRC16_POLY=16'hA001 and CRC16_INIT=16'hFFFF.
  - The err_code localparams (ERR_NONE, ERR_CRC, ERR_LEN, ERR_TIMEOUT).
  - The FSM state encoding.
- Sub-module crc16_byte_update is purely combinational: 16-bit crc_in and 8-bit data in, crc_out out, built as 8 unrolled reflected shift/XOR steps. It is instantiated once. The generator side may reuse it later.

## Test plan
- Frame 06 01 03 00 00 00 01 84 0A:
  - m_valid ×6 with m_last on 0x01.
  - frame_done with frame_ok=1, err_code=0, crc_calc=0x0A84, crc_rx=0x0A84.
- Frame 09 "123456789" 37 4B: frame_ok=1, crc_calc=0x4B37. The same frame with the last byte 4C gives frame_ok=0, err_code=1, crc_rx=0x4C37.
- LEN=00, then LEN=MAX_LEN+1: each gives a frame_done pulse one cycle after LEN with err_code=2 and no m_valid. The next valid frame then passes.
- Two valid frames back to back with s_valid held high: s_ready drops only in DONE; both frames pass and the total cycle count equals bytes + 2.
- With RX_TIMEOUT_EN, stall TIMEOUT_CYCLES after the third payload byte: frame_done with err_code=3. Without the macro, the same stall followed by the remaining bytes passes.
- rst_n pulsed low mid-payload: outputs return to their reset values asynchronously, and a complete frame afterwards passes.
